// File: rtl/bus_pkg.sv
// Shared types and address-map constants for the CPU data-bus interconnect.
// The decode function is the single source of truth for which slave owns an address.
package bus_pkg;

  typedef enum logic [1:0] {
    TGT_ROM  = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_UART = 2'd2,
    TGT_NONE = 2'd3
  } target_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [31:0] ROM_BASE_DEF  = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE_DEF  = 32'h1000_0000;
  localparam logic [31:0] UART_BASE_DEF = 32'h2000_0000;

  localparam logic [31:0] ROM_MASK  = 32'h0000_3FFF;
  localparam logic [31:0] RAM_MASK  = 32'h0000_FFFF;
  localparam logic [31:0] UART_MASK = 32'h0000_000F;

  // Region is chosen by the top nibble; any offset bit above the region size makes it unmapped.
  function automatic target_t decode_target(input logic [31:0] addr,
                                            input logic [31:0] rom_base,
                                            input logic [31:0] ram_base,
                                            input logic [31:0] uart_base);
    target_t t;
    t = TGT_NONE;
    if (addr[31:28] == rom_base[31:28] && (addr[27:0] & ~ROM_MASK[27:0]) == 28'd0)
      t = TGT_ROM;
    else if (addr[31:28] == ram_base[31:28] && (addr[27:0] & ~RAM_MASK[27:0]) == 28'd0)
      t = TGT_RAM;
    else if (addr[31:28] == uart_base[31:28] && (addr[27:0] & ~UART_MASK[27:0]) == 28'd0)
      t = TGT_UART;
    return t;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: byte address to target slave plus offset within that slave.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
  parameter logic [31:0] UART_BASE = UART_BASE_DEF
) (
  input  logic [31:0] addr_i,
  output target_t     target_o,
  output logic [31:0] offset_o
);

  always_comb begin
    target_o = decode_target(addr_i, ROM_BASE, RAM_BASE, UART_BASE);
    offset_o = 32'd0;
    case (target_o)
      TGT_ROM:  offset_o = addr_i - ROM_BASE;
      TGT_RAM:  offset_o = addr_i - RAM_BASE;
      TGT_UART: offset_o = addr_i - UART_BASE;
      default:  offset_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_bus_router.sv
// Single-master, three-slave data-bus router with one outstanding transaction.
// Holds only busy/target state; request demux and response mux are combinational.
module data_bus_router
  import bus_pkg::*;
#(
  parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
  parameter logic [31:0] UART_BASE = UART_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        rom_req,
  output logic        rom_we,
  output logic [31:0] rom_addr,
  output logic [31:0] rom_wdata,
  output logic [3:0]  rom_be,
  input  logic        rom_gnt,
  input  logic        rom_rvalid,
  input  logic [31:0] rom_rdata,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_be,
  input  logic        ram_gnt,
  input  logic        ram_rvalid,
  input  logic [31:0] ram_rdata,
  output logic        uart_req,
  output logic        uart_we,
  output logic [31:0] uart_addr,
  output logic [31:0] uart_wdata,
  output logic [3:0]  uart_be,
  input  logic        uart_gnt,
  input  logic        uart_rvalid,
  input  logic [31:0] uart_rdata,
  output state_t      dbg_state_o,
  output target_t     dbg_target_o
);

  // Handshake: a request is accepted in the cycle cpu_req && cpu_gnt; exactly one
  // cpu_rvalid pulse follows, and cpu_gnt stays low from accept through that pulse.

  state_t      state_q, state_d;
  target_t     target_q, target_d;
  target_t     sel;
  logic [31:0] offset;
  logic        busy;
  logic        accept;
  logic [31:0] resp_data;

  bus_addr_decoder #(
    .ROM_BASE  (ROM_BASE),
    .RAM_BASE  (RAM_BASE),
    .UART_BASE (UART_BASE)
  ) u_dec (
    .addr_i   (cpu_addr),
    .target_o (sel),
    .offset_o (offset)
  );

  assign busy   = (state_q == ST_BUSY);
  assign accept = cpu_req & cpu_gnt;

  assign rom_we     = cpu_we;
  assign rom_addr   = offset;
  assign rom_wdata  = cpu_wdata;
  assign rom_be     = cpu_be;
  assign ram_we     = cpu_we;
  assign ram_addr   = offset;
  assign ram_wdata  = cpu_wdata;
  assign ram_be     = cpu_be;
  assign uart_we    = cpu_we;
  assign uart_addr  = offset;
  assign uart_wdata = cpu_wdata;
  assign uart_be    = cpu_be;

  // Everything facing either side is forced quiet while reset is held.
  always_comb begin
    rom_req    = 1'b0;
    ram_req    = 1'b0;
    uart_req   = 1'b0;
    cpu_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    resp_data  = 32'd0;
    if (rst) begin
      case (sel)
        TGT_ROM:  begin rom_req  = cpu_req & ~busy; cpu_gnt = rom_gnt  & ~busy; end
        TGT_RAM:  begin ram_req  = cpu_req & ~busy; cpu_gnt = ram_gnt  & ~busy; end
        TGT_UART: begin uart_req = cpu_req & ~busy; cpu_gnt = uart_gnt & ~busy; end
        default:  cpu_gnt = ~busy;
      endcase
      if (busy) begin
        case (target_q)
          TGT_ROM:  begin cpu_rvalid = rom_rvalid;  resp_data = rom_rdata;  end
          TGT_RAM:  begin cpu_rvalid = ram_rvalid;  resp_data = ram_rdata;  end
          TGT_UART: begin cpu_rvalid = uart_rvalid; resp_data = uart_rdata; end
          default:  begin cpu_rvalid = 1'b1;        resp_data = 32'd0;      end
        endcase
      end
    end
    cpu_rdata = cpu_rvalid ? resp_data : 32'd0;
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d  = ST_BUSY;
        target_d = sel;
      end
      ST_BUSY: if (cpu_rvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      target_q <= TGT_NONE;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign dbg_state_o  = state_q;
  assign dbg_target_o = target_q;

endmodule

// File: tb/tb_data_bus_router.sv
// Directed bench for data_bus_router: slaves are driven by hand step by step,
// inputs change on the falling edge and outputs are checked 1 ns later.
module tb_data_bus_router;
  import bus_pkg::*;

  logic        clk, rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        rom_req, rom_we, ram_req, ram_we, uart_req, uart_we;
  logic [31:0] rom_addr, rom_wdata, ram_addr, ram_wdata, uart_addr, uart_wdata;
  logic [3:0]  rom_be, ram_be, uart_be;
  logic        rom_gnt, rom_rvalid, ram_gnt, ram_rvalid, uart_gnt, uart_rvalid;
  logic [31:0] rom_rdata, ram_rdata, uart_rdata;
  state_t      dbg_state;
  target_t     dbg_target;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  data_bus_router dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .rom_req(rom_req), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .rom_be(rom_be), .rom_gnt(rom_gnt), .rom_rvalid(rom_rvalid), .rom_rdata(rom_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_gnt(ram_gnt), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_be(uart_be), .uart_gnt(uart_gnt), .uart_rvalid(uart_rvalid), .uart_rdata(uart_rdata),
    .dbg_state_o(dbg_state), .dbg_target_o(dbg_target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_be    = be;
  endtask

  task automatic chk_resp(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    chk({tag, "_rvalid"}, {31'd0, cpu_rvalid}, 32'd1);
    chk({tag, "_rdata"}, cpu_rdata, e);
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_be = 4'h0;
    rom_gnt = 1'b1; ram_gnt = 1'b1; uart_gnt = 1'b1;
    rom_rvalid = 1'b0; ram_rvalid = 1'b0; uart_rvalid = 1'b0;
    rom_rdata = 32'd0; ram_rdata = 32'd0; uart_rdata = 32'd0;

    // reset state, with a live RAM request presented during reset
    cpu_drive(1'b0, 32'h1000_0000, 32'd0, 4'hF);
    #1 rst = 1'b0;
    #2;
    chk("rst_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    chk("rst_target", {30'd0, dbg_target}, {30'd0, TGT_NONE});
    @(negedge clk); rst = 1'b1; cpu_req = 1'b0;

    // RAM write
    @(negedge clk);
    cpu_drive(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("ramw_req", {31'd0, ram_req}, 32'd1);
    chk("ramw_addr", ram_addr, 32'h10);
    chk("ramw_we", {31'd0, ram_we}, 32'd1);
    chk("ramw_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("ramw_be", {28'd0, ram_be}, 32'hF);
    chk("ramw_rom_req", {31'd0, rom_req}, 32'd0);
    chk("ramw_uart_req", {31'd0, uart_req}, 32'd0);
    chk("ramw_gnt", {31'd0, cpu_gnt}, 32'd1);
    @(negedge clk);
    cpu_req = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'd0;
    exp_q.push_back(32'd0);
    #1;
    chk("ramw_state", {31'd0, dbg_state}, {31'd0, ST_BUSY});
    chk("ramw_busy_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk_resp("ramw");

    // RAM read, with busy masking and a stray ROM response while pending
    @(negedge clk);
    ram_rvalid = 1'b0;
    cpu_drive(1'b0, 32'h1000_0010, 32'd0, 4'hF);
    #1;
    chk("ramr_idle", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    chk("ramr_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("ramr_addr", ram_addr, 32'h10);
    chk("ramr_rom_req", {31'd0, rom_req}, 32'd0);
    chk("ramr_uart_req", {31'd0, uart_req}, 32'd0);
    @(negedge clk);
    cpu_drive(1'b0, 32'h0000_0004, 32'd0, 4'hF);
    rom_rvalid = 1'b1; rom_rdata = 32'h0000_0BAD;
    #1;
    chk("mask_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("mask_rom_req", {31'd0, rom_req}, 32'd0);
    chk("stray_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("stray_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rom_rvalid = 1'b0; rom_rdata = 32'd0;
    ram_rvalid = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    chk_resp("ramr");
    chk("ramr_resp_gnt", {31'd0, cpu_gnt}, 32'd0);

    // ROM read accepted on the cycle after the RAM response
    @(negedge clk);
    ram_rvalid = 1'b0; ram_rdata = 32'd0;
    #1;
    chk("rom_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("rom_req", {31'd0, rom_req}, 32'd1);
    chk("rom_addr", rom_addr, 32'h4);
    chk("rom_ram_req", {31'd0, ram_req}, 32'd0);
    @(negedge clk);
    cpu_req = 1'b0; rom_rvalid = 1'b1; rom_rdata = 32'h0000_0013;
    exp_q.push_back(32'h0000_0013);
    #1;
    chk_resp("rom");

    // UART write stalled by uart_gnt for 3 cycles
    @(negedge clk);
    rom_rvalid = 1'b0; rom_rdata = 32'd0;
    uart_gnt = 1'b0;
    cpu_drive(1'b1, 32'h2000_0000, 32'h0000_0041, 4'h1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("uart_stall_gnt", {31'd0, cpu_gnt}, 32'd0);
      chk("uart_stall_req", {31'd0, uart_req}, 32'd1);
    end
    @(negedge clk);
    uart_gnt = 1'b1;
    #1;
    chk("uart_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("uart_addr", uart_addr, 32'd0);
    chk("uart_wdata", uart_wdata, 32'h41);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("uart_wait_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    @(negedge clk);
    uart_rvalid = 1'b1;
    exp_q.push_back(32'd0);
    #1;
    chk_resp("uart");

    // unmapped region, then out-of-range RAM offset; stray RAM data must not leak
    @(negedge clk);
    uart_rvalid = 1'b0;
    cpu_drive(1'b0, 32'h3000_0000, 32'd0, 4'hF);
    #1;
    chk("none_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("none_reqs", {29'd0, rom_req, ram_req, uart_req}, 32'd0);
    @(negedge clk);
    cpu_req = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'h5555_5555;
    exp_q.push_back(32'd0);
    #1;
    chk_resp("none");
    chk("none_target", {30'd0, dbg_target}, {30'd0, TGT_NONE});
    @(negedge clk);
    ram_rvalid = 1'b0; ram_rdata = 32'd0;
    cpu_drive(1'b0, 32'h1001_0000, 32'd0, 4'hF);
    #1;
    chk("oor_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("oor_reqs", {29'd0, rom_req, ram_req, uart_req}, 32'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    exp_q.push_back(32'd0);
    #1;
    chk_resp("oor");
    @(negedge clk);
    #1;
    chk("oor_after_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("oor_after_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});

    // reset while a RAM read is pending; late rvalid after release ignored
    @(negedge clk);
    cpu_drive(1'b0, 32'h1000_0020, 32'd0, 4'hF);
    #1;
    chk("rstm_gnt", {31'd0, cpu_gnt}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstm_gnt_low", {31'd0, cpu_gnt}, 32'd0);
    chk("rstm_reqs", {29'd0, rom_req, ram_req, uart_req}, 32'd0);
    chk("rstm_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rstm_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0;
    ram_rvalid = 1'b1; ram_rdata = 32'h0000_0BAD;
    #1;
    chk("late_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("late_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    ram_rvalid = 1'b0; ram_rdata = 32'd0;
    cpu_drive(1'b0, 32'h0000_0008, 32'd0, 4'hF);
    #1;
    chk("post_rst_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("post_rst_rom_req", {31'd0, rom_req}, 32'd1);
    @(negedge clk);
    cpu_req = 1'b0; rom_rvalid = 1'b1; rom_rdata = 32'h00A0_0093;
    exp_q.push_back(32'h00A0_0093);
    #1;
    chk_resp("post_rst");
    @(negedge clk);
    rom_rvalid = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
